// File: rtl/branch_predictor_unit_pkg.sv
// Shared sizing helpers and counter encodings for the branch predictor.
// Everything here is elaborated at compile time from the unit's parameters.
package bp_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Weakly-taken is the value a freshly allocated conditional branch starts at.
    function automatic int ctr_weak_t(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

    function automatic int ctr_weak_nt(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    function automatic int tag_width(input int addr_w, input int idx_w);
        return addr_w - 2 - idx_w;
    endfunction

    // PCs are word-aligned, so the index starts at bit 2.
    function automatic logic [31:0] pc_index(input logic [63:0] pc, input int idx_w);
        return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
    endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Next-state logic for one saturating prediction counter.
// force_max wins over the taken/not-taken step.
module sat_counter_update #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_in,
    input  logic             inc,
    input  logic             force_max,
    output logic [CTR_W-1:0] ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (force_max) begin
            ctr_out = '1;
        end else if (inc) begin
            if (ctr_in != '1) begin
                ctr_out = ctr_in + CTR_W'(1);
            end
        end else if (ctr_in != '0) begin
            ctr_out = ctr_in - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// Tagged BTB with saturating counters and optional gshare indexing.
// Looked up combinationally in IF, trained from committed outcomes in MEM.
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int GSHARE  = 0,
    parameter int HIST_W  = 4,
    localparam int IDX_W  = clog2(ENTRIES)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] IF_PC,
    output logic [ADDR_W-1:0] Pred_NextPC,
    output logic              Pred_Taken,
    output logic [IDX_W-1:0]  Pred_Idx,
    input  logic              Upd_Valid,
    input  logic              Upd_Uncond,
    input  logic [ADDR_W-1:0] Upd_PC,
    input  logic [IDX_W-1:0]  Upd_Idx,
    input  logic              Upd_Taken,
    input  logic [ADDR_W-1:0] Upd_Target,
    input  logic              Upd_PredTaken,
    input  logic [ADDR_W-1:0] Upd_PredNextPC,
    output logic              Mispredict,
    output logic [ADDR_W-1:0] Recover_PC,
    output logic [31:0]       Branch_Count,
    output logic [31:0]       Mispredict_Count
);

    localparam int TAG_W = tag_width(ADDR_W, IDX_W);
    localparam logic [CTR_W-1:0] CTR_INIT  = CTR_W'(ctr_weak_nt(CTR_W));
    localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_weak_t(CTR_W));

    logic              valid_reg  [ENTRIES];
    logic [TAG_W-1:0]  tag_reg    [ENTRIES];
    logic [ADDR_W-1:0] target_reg [ENTRIES];
    logic [CTR_W-1:0]  ctr_reg    [ENTRIES];

    logic [31:0] branch_count_reg;
    logic [31:0] mispredict_count_reg;

    logic [IDX_W-1:0]  if_pc_idx;
    logic [IDX_W-1:0]  hist_idx;
    logic [IDX_W-1:0]  lookup_idx;
    logic [TAG_W-1:0]  if_tag;
    logic              lookup_hit;

    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic [CTR_W-1:0]  hit_ctr_next;
    logic [CTR_W-1:0]  upd_ctr_next;
    logic              table_wr;
    logic              target_wr;
    logic [ENTRIES-1:0] entry_wr;
    logic [ENTRIES-1:0] entry_target_wr;

    // ------------------------------------------------------------------
    // Index generation; history only exists in gshare mode
    // ------------------------------------------------------------------
    assign if_pc_idx = IDX_W'(pc_index(64'(IF_PC), IDX_W));

    generate
        if (GSHARE != 0) begin : g_gshare
            logic [HIST_W-1:0] ghr_reg;

            // History tracks committed conditional outcomes only; jumps carry no information.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    ghr_reg <= '0;
                end else if (Upd_Valid && !Upd_Uncond) begin
                    ghr_reg <= HIST_W'({ghr_reg, Upd_Taken});
                end
            end

            always_comb begin
                hist_idx = '0;
                hist_idx[HIST_W-1:0] = ghr_reg;
            end
        end else begin : g_pc_only
            assign hist_idx = '0;
        end
    endgenerate

    assign lookup_idx = if_pc_idx ^ hist_idx;

    // ------------------------------------------------------------------
    // Lookup: reads registered state, so a same-cycle update is not visible
    // ------------------------------------------------------------------
    assign if_tag      = IF_PC[ADDR_W-1:IDX_W+2];
    assign lookup_hit  = valid_reg[lookup_idx] && (tag_reg[lookup_idx] == if_tag);
    assign Pred_Taken  = lookup_hit && ctr_reg[lookup_idx][CTR_W-1];
    assign Pred_NextPC = Pred_Taken ? target_reg[lookup_idx] : IF_PC + ADDR_W'(4);
    assign Pred_Idx    = lookup_idx;

    // ------------------------------------------------------------------
    // Training path
    // ------------------------------------------------------------------
    assign upd_tag = Upd_PC[ADDR_W-1:IDX_W+2];
    assign upd_hit = valid_reg[Upd_Idx] && (tag_reg[Upd_Idx] == upd_tag);

    sat_counter_update #(
        .CTR_W (CTR_W)
    ) u_sat_counter_update (
        .ctr_in    (ctr_reg[Upd_Idx]),
        .inc       (Upd_Taken),
        .force_max (Upd_Uncond),
        .ctr_out   (hit_ctr_next)
    );

    always_comb begin
        upd_ctr_next = hit_ctr_next;
        if (!upd_hit) begin
            upd_ctr_next = Upd_Uncond ? '1 : CTR_ALLOC;
        end
    end

    // A not-taken miss leaves the table alone so it cannot evict a useful entry.
    assign table_wr  = Upd_Valid && (upd_hit || Upd_Taken);
    assign target_wr = Upd_Valid && (Upd_Taken || (upd_hit && Upd_Uncond));

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry_decode
            assign entry_wr[gi]        = table_wr  && (Upd_Idx == IDX_W'(gi));
            assign entry_target_wr[gi] = target_wr && (Upd_Idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                ctr_reg[i]    <= CTR_INIT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (entry_wr[i]) begin
                    valid_reg[i] <= 1'b1;
                    tag_reg[i]   <= upd_tag;
                    ctr_reg[i]   <= upd_ctr_next;
                end
                if (entry_target_wr[i]) begin
                    target_reg[i] <= Upd_Target;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Recovery and performance counters
    // ------------------------------------------------------------------
    assign Mispredict = Upd_Valid &&
                        ((Upd_PredTaken != Upd_Taken) ||
                         (Upd_Taken && (Upd_PredNextPC != Upd_Target)));
    assign Recover_PC = Upd_Taken ? Upd_Target : Upd_PC + ADDR_W'(4);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            if (Upd_Valid && (branch_count_reg != '1)) begin
                branch_count_reg <= branch_count_reg + 32'd1;
            end
            if (Mispredict && (mispredict_count_reg != '1)) begin
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
            end
        end
    end

    assign Branch_Count     = branch_count_reg;
    assign Mispredict_Count = mispredict_count_reg;

endmodule
